display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the clock's common-anode 7-segment display bank. It holds a per-frame shadow copy of the digit codes and walks through the digits one slot at a time. On each slot it drives the shared 4-bit code into the 7-segment decoder and enables one active-low anode, with a dead-time gap between slots to stop ghosting. It also applies leading-zero suppression, per-digit blink (used by time-set mode) and the decimal-point drive.

---
 rtl/display_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank.
// Latches a frame shadow, walks slots with dead time, applies blink and leading-zero blanking.
module display_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_DIV    = 25000000,
  localparam int SLOT_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CYC_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1,
  localparam int BLK_W       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [4*DIGITS-1:0]   i_digits,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blink_mask,
  input  logic                  i_lz_blank,
  output logic [3:0]            o_digit,
  output logic [DIGITS-1:0]     o_anode,
  output logic                  o_dp,
  output logic [SLOT_W-1:0]     o_slot,
  output logic                  o_frame_start
);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_e;

  state_e                   state_q, state_d;
  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic [CYC_W-1:0]         cyc_q, cyc_d;
  logic [BLK_W-1:0]         blink_cnt_q, blink_cnt_d;
  logic                     blink_phase_q, blink_phase_d;
  logic [DIGITS-1:0][3:0]   sh_dig_q, sh_dig_d;
  logic [DIGITS-1:0]        sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]        sh_mask_q, sh_mask_d;
  logic                     sh_lz_q, sh_lz_d;
  logic                     frame_start_q, frame_start_d;
  logic                     load;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    cyc_d         = cyc_q;
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    sh_dig_d      = sh_dig_q;
    sh_dp_d       = sh_dp_q;
    sh_mask_d     = sh_mask_q;
    sh_lz_d       = sh_lz_q;
    load          = 1'b0;

    if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

    case (state_q)
      S_IDLE: begin
        slot_d = '0;
        cyc_d  = '0;
        if (i_en) begin
          state_d = S_BLANK;
          load    = 1'b1;
        end
      end
      S_BLANK: begin
        cyc_d = cyc_q + 1'b1;
        if (!i_en) begin
          state_d = S_IDLE;
          slot_d  = '0;
          cyc_d   = '0;
        end else if (cyc_q == CYC_W'(BLANK_CYCLES - 1)) begin
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        cyc_d = cyc_q + 1'b1;
        if (!i_en) begin
          state_d = S_IDLE;
          slot_d  = '0;
          cyc_d   = '0;
        end else if (cyc_q == CYC_W'(REFRESH_DIV - 1)) begin
          state_d = S_BLANK;
          cyc_d   = '0;
          if (slot_q == SLOT_W'(DIGITS - 1)) begin
            slot_d = '0;
            load   = 1'b1;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        slot_d  = '0;
        cyc_d   = '0;
      end
    endcase

    frame_start_d = load;
    if (load) begin
      sh_dig_d  = i_digits;
      sh_dp_d   = i_dp;
      sh_mask_d = i_blink_mask;
      sh_lz_d   = i_lz_blank;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      slot_q        <= '0;
      cyc_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sh_dig_q      <= '1;
      sh_dp_q       <= '0;
      sh_mask_q     <= '0;
      sh_lz_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      cyc_q         <= cyc_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      sh_dig_q      <= sh_dig_d;
      sh_dp_q       <= sh_dp_d;
      sh_mask_q     <= sh_mask_d;
      sh_lz_q       <= sh_lz_d;
      frame_start_q <= frame_start_d;
    end
  end

  // zero_from[k]: every shadow nibble from k up to the leftmost digit is zero
  logic [DIGITS-1:0] zero_from;
  always_comb begin
    logic run;
    run       = 1'b1;
    zero_from = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run          = run & (sh_dig_q[k] == 4'd0);
      zero_from[k] = run;
    end
  end

  logic hide_blink, hide_lz;
  assign hide_blink = blink_phase_q & sh_mask_q[slot_q];
  assign hide_lz    = sh_lz_q & (slot_q != '0) & zero_from[slot_q];

  always_comb begin
    o_anode = '1;
    o_digit = 4'hF;
    o_dp    = 1'b1;
    if (state_q == S_DRIVE) begin
      o_anode = ~(DIGITS'(1) << slot_q);
      if (hide_blink) begin
        o_digit = 4'hF;
        o_dp    = 1'b1;
      end else if (hide_lz) begin
        o_digit = 4'hF;
        o_dp    = ~sh_dp_q[slot_q];
      end else begin
        o_digit = sh_dig_q[slot_q];
        o_dp    = ~sh_dp_q[slot_q];
      end
    end
  end

  assign o_slot        = slot_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a timeline model:
// position within the running period, frame-sampled shadow, blink phase from elapsed clocks.
module tb_display_scan_ctrl;
  localparam int DIGITS = 4, RDIV = 8, BCYC = 2, BDIV = 64;
  localparam int FRAME  = DIGITS * RDIV;

  logic        i_clk = 1'b0;
  logic        i_rst, i_en, i_lz_blank;
  logic [15:0] i_digits;
  logic [3:0]  i_dp, i_blink_mask;
  logic [3:0]  o_digit, o_anode;
  logic        o_dp, o_frame_start;
  logic [1:0]  o_slot;

  display_scan_ctrl #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV), .BLANK_CYCLES(BCYC), .BLINK_DIV(BDIV)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_digits(i_digits), .i_dp(i_dp),
    .i_blink_mask(i_blink_mask), .i_lz_blank(i_lz_blank), .o_digit(o_digit),
    .o_anode(o_anode), .o_dp(o_dp), .o_slot(o_slot), .o_frame_start(o_frame_start)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, exp);
    end
  endtask

  // model: m_t = clocks since the display started running, m_bt = clocks since reset
  bit          m_run;
  int          m_t, m_bt;
  logic [15:0] m_dig;
  logic [3:0]  m_dp, m_mask;
  logic        m_lz;

  task automatic load_shadow();
    m_dig = i_digits; m_dp = i_dp; m_mask = i_blink_mask; m_lz = i_lz_blank;
  endtask

  task automatic model_step();
    if (i_rst) begin
      m_run = 0; m_t = 0; m_bt = 0;
      m_dig = 16'hFFFF; m_dp = 0; m_mask = 0; m_lz = 0;
    end else begin
      m_bt++;
      if (!m_run) begin
        if (i_en) begin m_run = 1; m_t = 0; load_shadow(); end
      end else if (!i_en) begin
        m_run = 0; m_t = 0;
      end else begin
        m_t++;
        if (m_t % FRAME == 0) load_shadow();
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] e_anode, e_digit;
    logic       e_dp, e_fs;
    int         e_slot, p, nib;
    e_anode = 4'hF; e_digit = 4'hF; e_dp = 1'b1; e_fs = 1'b0; e_slot = 0;
    if (m_run) begin
      p      = m_t % FRAME;
      e_slot = p / RDIV;
      e_fs   = (p == 0);
      if (p % RDIV >= BCYC) begin
        e_anode = 4'hF & ~(4'(1) << e_slot);
        nib     = int'((m_dig >> (4 * e_slot)) & 16'hF);
        if (((m_bt / BDIV) % 2 == 1) && m_mask[e_slot]) begin
          e_digit = 4'hF; e_dp = 1'b1;
        end else if (m_lz && e_slot != 0 && (m_dig >> (4 * e_slot)) == 16'd0) begin
          e_digit = 4'hF; e_dp = ~m_dp[e_slot];
        end else begin
          e_digit = 4'(nib); e_dp = ~m_dp[e_slot];
        end
      end
    end
    chk("anode", 32'(o_anode), 32'(e_anode));
    chk("digit", 32'(o_digit), 32'(e_digit));
    chk("dp", 32'(o_dp), 32'(e_dp));
    chk("slot", 32'(o_slot), 32'(e_slot));
    chk("frame_start", 32'(o_frame_start), 32'(e_fs));
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] d;
    for (int k = 0; k < 4; k++) d[4*k +: 4] = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom % 16);
    return d;
  endfunction

  // one clock: model follows the edge, outputs checked mid-cycle; random perturbation optional
  task automatic cycle(input bit perturb);
    int r;
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    check_outputs();
    if (perturb) begin
      r = int'($urandom % 1000);
      i_rst = (r < 4);
      if (r >= 4 && r < 12) i_en = 1'b0;
      else if (!i_en && r > 600) i_en = 1'b1;
      if ($urandom % 12 == 0) i_digits = rand_digits();
      if ($urandom % 40 == 0) i_dp = 4'($urandom);
      if ($urandom % 40 == 0) i_blink_mask = 4'($urandom);
      if ($urandom % 40 == 0) i_lz_blank = 1'($urandom);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_digits = 16'h1234; i_dp = 0; i_blink_mask = 0; i_lz_blank = 0;
    run(3);
    i_rst = 1'b0; i_en = 1'b1;
    run(FRAME + RDIV + 2);
    i_digits = 16'h5678;                 // mid-frame change, slot 1
    run(FRAME + RDIV);
    i_lz_blank = 1'b1; i_digits = 16'h0050; run(FRAME + 4);
    i_digits = 16'h0000; run(FRAME);
    i_digits = 16'h00C0; run(FRAME);
    i_lz_blank = 1'b0; i_digits = 16'h0050; run(FRAME + 2);
    i_blink_mask = 4'b0010; i_dp = 4'b0010; i_digits = 16'h1234; run(4 * BDIV);
    i_blink_mask = 4'b0000; i_dp = 4'b0100; run(2 * FRAME);
    while (!(o_slot == 2'd2 && o_anode == 4'b1011)) run(1);
    i_en = 1'b0; run(3);
    i_en = 1'b1; run(FRAME + 5);
    i_rst = 1'b1; run(2);
    i_rst = 1'b0; run(FRAME + 3);
    for (int i = 0; i < 4000; i++) cycle(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
